// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time instruction-memory loader.
//   state_t     - loader FSM state encoding
//   HDR_BYTES   - bytes in the word-count header
//   WORD_BYTES  - bytes per instruction word (and per checksum)
//   CSUM_BYTES  - bytes in the trailing checksum
//   word_addr() - byte address of word k relative to a base address
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_BYTES = WORD_BYTES;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] k);
    return base + (k << 2);
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// byte_to_word: big-endian shift assembler turning a byte stream into
// 32-bit words.
//   clk, reset  - clock and synchronous active-high reset
//   clear       - drop any partially assembled word
//   byte_valid  - byte_data is consumed this cycle
//   byte_data   - incoming byte (first byte lands in word[31:24])
//   word        - assembled word; meaningful only while word_valid is high
//   word_valid  - strobe: the byte consumed this cycle completes a word
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  // Only the three earlier bytes need storing; the fourth is taken straight
  // from the input so the completed word is available in its arrival cycle.
  logic [1:0]  count_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_valid) begin
      shift_reg <= {shift_reg[15:0], byte_data};
      count_reg <= count_reg + 2'd1;  // wraps 3 -> 0 at each word boundary
    end
  end

  assign word       = {shift_reg, byte_data};
  assign word_valid = byte_valid && (count_reg == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program image from a byte stream into instruction
// memory and holds the core in reset until the image verifies.
// Image: 2-byte word count N, N big-endian words, XOR-of-words checksum.
//   clk, reset - clock and synchronous active-high reset
//   in_valid   - byte offered on in_data
//   in_data    - stream byte
//   in_ready   - byte accepted when in_valid & in_ready
//   imem_we    - one-cycle write strobe per instruction word
//   imem_a     - byte address of the write
//   imem_wd    - word written
//   cpu_hold   - core reset request, released once done
//   done       - image loaded and checksum matched (sticky)
//   error      - oversize image or checksum mismatch (sticky)
module imem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t          state_reg, state_next;
  logic [7:0]      n_hi_reg;
  logic [CW-1:0]   n_reg;
  logic [CW-1:0]   k_reg;
  logic [31:0]     csum_reg;
  logic            imem_we_reg;
  logic [31:0]     imem_a_reg;
  logic [31:0]     imem_wd_reg;

  logic            accept;
  logic            asm_valid;
  logic            asm_clear;
  logic [31:0]     asm_word;
  logic            asm_word_valid;
  logic [15:0]     header_n;
  logic            last_word;

  assign in_ready = !reset && (state_reg inside {HDR_HI, HDR_LO, DATA, CSUM});
  assign accept   = in_valid && in_ready;

  // The assembler sees only payload bytes; holding it clear while waiting
  // for a header guarantees every image starts on a word boundary.
  assign asm_valid = accept && (state_reg inside {DATA, CSUM});
  assign asm_clear = (state_reg == HDR_HI);

  assign header_n  = {n_hi_reg, in_data};
  assign last_word = ((k_reg + CW'(1)) == n_reg);

  byte_to_word u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (in_data),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= HDR_HI;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if ({1'b0, header_n} > 17'(DEPTH)) state_next = ERROR;
          else if (header_n == 16'd0)        state_next = CSUM;
          else                               state_next = DATA;
        end
      end
      DATA:   if (asm_word_valid && last_word) state_next = CSUM;
      CSUM: begin
        if (asm_word_valid)
          state_next = (asm_word == csum_reg) ? DONE : ERROR;
      end
      default: state_next = state_reg;  // DONE / ERROR hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_hi_reg    <= 8'd0;
      n_reg       <= '0;
      k_reg       <= '0;
      csum_reg    <= 32'd0;
      imem_we_reg <= 1'b0;
      imem_a_reg  <= BASE_ADDR;
      imem_wd_reg <= 32'd0;
    end else begin
      imem_we_reg <= 1'b0;
      if (accept && state_reg == HDR_HI) n_hi_reg <= in_data;
      // Truncation is harmless: an oversize count never leaves HDR_LO
      // for DATA, so n_reg is only used when it fits.
      if (accept && state_reg == HDR_LO) n_reg <= CW'(header_n);
      if (asm_word_valid && state_reg == DATA) begin
        imem_we_reg <= 1'b1;
        imem_a_reg  <= word_addr(BASE_ADDR, 32'(k_reg));
        imem_wd_reg <= asm_word;
        csum_reg    <= csum_reg ^ asm_word;
        k_reg       <= k_reg + CW'(1);
      end
    end
  end

  assign imem_we  = imem_we_reg;
  assign imem_a   = imem_a_reg;
  assign imem_wd  = imem_wd_reg;
  assign done     = (state_reg == DONE);
  assign error    = (state_reg == ERROR);
  assign cpu_hold = !done;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. A byte
// stream is built per scenario; the expected behaviour is derived directly
// from the image format (header count, word positions, XOR checksum).
module tb_imem_loader;
  import loader_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_a;
  logic [31:0] imem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .imem_we  (imem_we),
    .imem_a   (imem_a),
    .imem_wd  (imem_wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] stream[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  // Reference model: pure functions of the stream contents.
  function automatic int hdr_n();
    return {stream[0], stream[1]};
  endfunction

  function automatic logic [31:0] word_at(input int k);
    int b;
    b = HDR_BYTES + WORD_BYTES * k;
    return {stream[b], stream[b+1], stream[b+2], stream[b+3]};
  endfunction

  function automatic int accept_limit();
    if (hdr_n() > DEPTH) return HDR_BYTES;
    return HDR_BYTES + WORD_BYTES * hdr_n() + CSUM_BYTES;
  endfunction

  function automatic bit csum_ok();
    logic [31:0] x;
    x = 32'd0;
    for (int k = 0; k < hdr_n(); k++) x ^= word_at(k);
    return x == word_at(hdr_n());
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_we", 32'(imem_we), 32'd0);
      check_eq("rst_a", imem_a, BASE);
      check_eq("rst_wd", imem_wd, 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_error", 32'(error), 32'd0);
      check_eq("rst_hold", 32'(cpu_hold), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
  endtask

  // mode 0: continuous, 1: in_valid toggles each cycle, 2: random gaps.
  // abort_at >= 0 stops once that many bytes were accepted (mid-image).
  task automatic run_stream(input int mode, input int abort_at, input string name);
    int pos, limit, n, cyc, last_wr, tail, k, budget;
    bit tog, valid, acc, exp_we, fin, exp_done;
    pos = 0; cyc = 0; last_wr = -1; tail = 0; tog = 1'b1;
    limit = accept_limit();
    n = hdr_n();
    budget = limit * 8 + 50;
    while (cyc < budget) begin
      @(negedge clk);
      case (mode)
        0: valid = 1'b1;
        1: begin valid = tog; tog = ~tog; end
        default: valid = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = valid;
      in_data = (pos < stream.size()) ? stream[pos] : 8'($urandom);
      #1;
      check_eq({name, "_in_ready"}, 32'(in_ready), 32'(pos < limit));
      @(posedge clk);
      acc = valid && (pos < limit);
      if (acc) pos++;
      #1;
      exp_we = acc && (n <= DEPTH) && (pos >= HDR_BYTES + WORD_BYTES) &&
               ((pos - HDR_BYTES) % WORD_BYTES == 0) &&
               ((pos - HDR_BYTES) / WORD_BYTES <= n);
      check_eq({name, "_we"}, 32'(imem_we), 32'(exp_we));
      if (exp_we) begin
        k = (pos - HDR_BYTES) / WORD_BYTES - 1;
        check_eq({name, "_addr"}, imem_a, BASE + 32'(4 * k));
        check_eq({name, "_data"}, imem_wd, word_at(k));
        if (mode == 1 && last_wr >= 0)
          check_eq({name, "_spacing"}, 32'(cyc - last_wr), 32'd8);
        last_wr = cyc;
        $display("%s: write a=%h wd=%h", name, imem_a, imem_wd);
      end
      fin = (pos >= limit);
      exp_done = fin && (n <= DEPTH) && csum_ok();
      check_eq({name, "_done"}, 32'(done), 32'(exp_done));
      check_eq({name, "_error"}, 32'(error), 32'(fin && !exp_done));
      check_eq({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
      cyc++;
      if (abort_at >= 0 && pos >= abort_at) break;
      if (fin) begin
        tail++;
        if (tail > 3) break;
      end
    end
    in_valid = 1'b0;
    if (abort_at >= 0) check_eq({name, "_progress"}, 32'(pos), 32'(abort_at));
    else               check_eq({name, "_progress"}, 32'(pos), 32'(limit));
    $display("%s: accepted=%0d done=%0b error=%0b", name, pos, done, error);
  endtask

  task automatic build_random(input int n, input bit good);
    logic [31:0] w, x;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    x = 32'd0;
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        x ^= w;
        push_word(w);
      end
      push_word(good ? x : (x ^ (32'd1 << $urandom_range(0, 31))));
    end
    for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
  endtask

  task automatic two_word(input logic [31:0] csum);
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h02);
    push_word(32'h2008_0005);
    push_word(32'h2009_000A);
    push_word(csum);
  endtask

  initial begin
    do_reset();
    two_word(32'h0001_000F);
    run_stream(0, -1, "basic");

    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    push_word(32'h0);
    run_stream(0, -1, "empty");

    do_reset();
    two_word(32'h0000_0000);
    run_stream(2, -1, "badsum");

    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h41);
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    run_stream(0, -1, "oversize");

    do_reset();
    two_word(32'h0001_000F);
    run_stream(1, -1, "toggle");

    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h03);
    push_word(32'hDEAD_BEEF);
    run_stream(0, 4, "partial");
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    push_word(32'h8C01_0004);
    push_word(32'h8C01_0004);
    run_stream(0, -1, "reload");

    do_reset();
    build_random(DEPTH, 1'b1);
    run_stream(0, -1, "full_depth");

    for (int t = 0; t < 20; t++) begin
      int n;
      do_reset();
      if ($urandom_range(0, 7) == 0) n = $urandom_range(DEPTH + 1, 65535);
      else                           n = $urandom_range(0, 10);
      build_random(n, $urandom_range(0, 3) != 0);
      run_stream($urandom_range(0, 2), -1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
